power_rail_sequencer: RTL and testbench

Parametrised successor to the board-level rail-enable debug logic. It drives N_RAIL power-rail enables plus mirrored LEDs from push-buttons. Push-buttons are debounced, and rails are powered up in index order and down in reverse order, with a programmable inter-rail delay. A manual mode toggles individual rails. Rails flagged in ALWAYS_ON are held enabled unconditionally. The block sits in the board-I/O debug top, between the GPIO switches and the PCB regulator-enable pins.

---
 rtl/power_rail_sequencer.sv | 173 +++++++++++++++++
 tb/tb_power_rail_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/power_rail_sequencer.sv
// Rail-enable sequencer: debounced push-buttons ramp N_RAIL regulator enables up in
// index order and down in reverse, with a manual per-rail toggle mode.
module power_rail_sequencer #(
  parameter int                DEB_CYC   = 1000000,
  parameter int                STEP_DLY  = 100000,
  parameter int                N_RAIL    = 5,
  parameter logic [N_RAIL-1:0] ALWAYS_ON = N_RAIL'(5'b01000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic [N_RAIL-1:0] btn_rail,
  input  logic              mode_manual,
  output logic [N_RAIL-1:0] rail_en,
  output logic [N_RAIL-1:0] led_en,
  output logic [1:0]        state_o,
  output logic              busy,
  output logic              all_on
);

  localparam int NB    = N_RAIL + 2;
  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam int TMR_W = $clog2(STEP_DLY + 1);
  localparam int IDX_W = (N_RAIL > 1) ? $clog2(N_RAIL) : 1;
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [TMR_W-1:0]  STEP_LAST = TMR_W'(STEP_DLY - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(N_RAIL - 1);
  localparam logic [N_RAIL-1:0] SEQ_MASK  = ~ALWAYS_ON;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_UP  = 2'd1,
    S_ON  = 2'd2,
    S_DN  = 2'd3
  } state_t;

  logic [NB-1:0]    btn_raw, btn_p0, btn_p1, deb, deb_d, pls;
  logic [CNT_W-1:0] cnt [NB];
  logic             mode_p0, mode_p1, mode_d;
  logic             up_p, dn_p;
  logic [N_RAIL-1:0] rail_p;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [TMR_W-1:0]  tmr, tmr_n;
  logic [N_RAIL-1:0] rail_q, led_q, rail_n;
  logic              step_done, seq_all_on, seq_all_off;

  assign btn_raw = {btn_rail, btn_dn, btn_up};

  // Stage p0/p1: two-flop synchronisers, then per-input stability counters
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0  <= '0;
      btn_p1  <= '0;
      deb     <= '0;
      deb_d   <= '0;
      mode_p0 <= 1'b0;
      mode_p1 <= 1'b0;
      mode_d  <= 1'b0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      btn_p0  <= btn_raw;
      btn_p1  <= btn_p0;
      deb_d   <= deb;
      mode_p0 <= mode_manual;
      mode_p1 <= mode_p0;
      mode_d  <= mode_p1;
      for (int i = 0; i < NB; i++) begin
        if (btn_p1[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= btn_p1[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pls    = deb & ~deb_d;
  assign up_p   = pls[0];
  assign dn_p   = pls[1];
  assign rail_p = pls[NB-1:2];

  // Stage p2: sequencer state and the enable register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_OFF;
      idx    <= '0;
      tmr    <= '0;
      rail_q <= ALWAYS_ON;
      led_q  <= ALWAYS_ON;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      tmr    <= tmr_n;
      rail_q <= rail_n | ALWAYS_ON;
      led_q  <= rail_n | ALWAYS_ON;
    end
  end

  assign step_done   = (tmr == STEP_LAST);
  assign seq_all_on  = ((rail_q & SEQ_MASK) == SEQ_MASK);
  assign seq_all_off = ((rail_q & SEQ_MASK) == '0);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tmr_n   = tmr;
    rail_n  = rail_q;
    case (state)
      S_OFF, S_ON: begin
        if (mode_p1) begin
          rail_n = rail_q ^ (rail_p & SEQ_MASK);
        end else if (mode_d) begin
          // Leaving manual mode: settle on whichever end state matches the rails
          if (seq_all_on) begin
            state_n = S_ON;
          end else if (seq_all_off) begin
            state_n = S_OFF;
          end else begin
            state_n = S_DN;
            idx_n   = IDX_TOP;
            tmr_n   = '0;
          end
        end else if (state == S_OFF && up_p) begin
          state_n = S_UP;
          idx_n   = '0;
          tmr_n   = '0;
        end else if (state == S_ON && dn_p) begin
          state_n = S_DN;
          idx_n   = IDX_TOP;
          tmr_n   = '0;
        end
      end
      S_UP: begin
        if (dn_p && !mode_p1) begin
          state_n = S_DN;
          tmr_n   = '0;
        end else begin
          rail_n[idx] = 1'b1;
          if (step_done) begin
            tmr_n = '0;
            if (idx == IDX_TOP) state_n = S_ON;
            else                idx_n   = idx + 1'b1;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
      end
      default: begin
        rail_n[idx] = 1'b0;
        if (step_done) begin
          tmr_n = '0;
          if (idx == '0) state_n = S_OFF;
          else           idx_n   = idx - 1'b1;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
    endcase
  end

  assign rail_en = rail_q;
  assign led_en  = led_q;
  assign state_o = state;
  assign busy    = (state == S_UP) || (state == S_DN);
  assign all_on  = (state == S_ON);

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Directed bench for power_rail_sequencer with N_RAIL=5, DEB_CYC=4, STEP_DLY=8,
// ALWAYS_ON=5'b01000; edge counts below are relative to the first sampling edge of a press.
module tb_power_rail_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_dn, mode_manual;
  logic [4:0] btn_rail;
  logic [4:0] rail_en, led_en;
  logic [1:0] state_o;
  logic       busy, all_on;

  int n_vec = 0;
  int n_bad = 0;

  power_rail_sequencer #(
    .DEB_CYC  (4),
    .STEP_DLY (8),
    .N_RAIL   (5),
    .ALWAYS_ON(5'b01000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .btn_rail   (btn_rail),
    .mode_manual(mode_manual),
    .rail_en    (rail_en),
    .led_en     (led_en),
    .state_o    (state_o),
    .busy       (busy),
    .all_on     (all_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rail, LED mirror and state in one go
  task automatic chk_rs(input string tag, input logic [4:0] exp_rail, input logic [1:0] exp_st);
    chk({tag, ".rail"}, {3'b0, rail_en}, {3'b0, exp_rail});
    chk({tag, ".led"}, {3'b0, led_en}, {3'b0, exp_rail});
    chk({tag, ".state"}, {6'b0, state_o}, {6'b0, exp_st});
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_rail = '0; mode_manual = 1'b0;
    wait_edges(3);
    chk_rs("reset", 5'b01000, 2'd0);
    chk("reset.busy", {7'b0, busy}, 8'd0);
    chk("reset.all_on", {7'b0, all_on}, 8'd0);
    rst = 1'b0;
    wait_edges(2);

    // 1. Power-up sequence
    btn_up = 1'b1;
    wait_edges(7);  chk_rs("up.e6", 5'b01000, 2'd1);
    chk("up.e6.busy", {7'b0, busy}, 8'd1);
    wait_edges(1);  chk_rs("up.e7", 5'b01001, 2'd1);
    wait_edges(8);  chk_rs("up.e15", 5'b01011, 2'd1);
    wait_edges(8);  chk_rs("up.e23", 5'b01111, 2'd1);
    wait_edges(8);  chk_rs("up.e31", 5'b01111, 2'd1);
    wait_edges(8);  chk_rs("up.e39", 5'b11111, 2'd1);
    wait_edges(8);  chk_rs("up.e47", 5'b11111, 2'd2);
    chk("up.e47.all_on", {7'b0, all_on}, 8'd1);
    chk("up.e47.busy", {7'b0, busy}, 8'd0);
    btn_up = 1'b0;
    wait_edges(10);

    // 2. Power-down sequence from ON
    btn_dn = 1'b1;
    wait_edges(7);  chk_rs("dn.e6", 5'b11111, 2'd3);
    btn_dn = 1'b0;
    wait_edges(1);  chk_rs("dn.e7", 5'b01111, 2'd3);
    wait_edges(8);  chk_rs("dn.e15", 5'b01111, 2'd3);
    wait_edges(8);  chk_rs("dn.e23", 5'b01011, 2'd3);
    wait_edges(8);  chk_rs("dn.e31", 5'b01001, 2'd3);
    wait_edges(8);  chk_rs("dn.e39", 5'b01000, 2'd3);
    wait_edges(8);  chk_rs("dn.e47", 5'b01000, 2'd0);
    chk("dn.e47.busy", {7'b0, busy}, 8'd0);
    wait_edges(5);

    // 3. Abort at idx 2, then an ignored up press during the ramp down
    btn_up = 1'b1;
    wait_edges(8);
    btn_up = 1'b0;
    wait_edges(12);
    btn_dn = 1'b1;
    wait_edges(7);  chk_rs("abort.e26", 5'b01111, 2'd3);
    btn_dn = 1'b0;
    btn_up = 1'b1;
    wait_edges(1);  chk_rs("abort.e27", 5'b01011, 2'd3);
    wait_edges(8);  chk_rs("abort.e35", 5'b01001, 2'd3);
    btn_up = 1'b0;
    wait_edges(8);  chk_rs("abort.e43", 5'b01000, 2'd3);
    wait_edges(8);  chk_rs("abort.e51", 5'b01000, 2'd0);
    wait_edges(5);

    // 4. Debounce: short glitch rejected, minimum press accepted, up+dn together
    btn_up = 1'b1;
    wait_edges(3);
    btn_up = 1'b0;
    wait_edges(10); chk_rs("glitch", 5'b01000, 2'd0);
    btn_up = 1'b1;
    wait_edges(4);
    btn_up = 1'b0;
    wait_edges(2);  chk_rs("press.e5", 5'b01000, 2'd0);
    wait_edges(1);  chk_rs("press.e6", 5'b01000, 2'd1);
    wait_edges(5);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    wait_edges(7);  chk_rs("both.e18", 5'b01011, 2'd3);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_edges(1);  chk_rs("both.e19", 5'b01001, 2'd3);
    wait_edges(19); chk_rs("both.e38", 5'b01000, 2'd0);
    wait_edges(5);

    // 5. Manual toggles and the exit back to sequenced mode
    mode_manual = 1'b1;
    wait_edges(3);
    btn_rail = 5'b00100;
    wait_edges(7);  chk_rs("man.r2", 5'b01100, 2'd0);
    btn_rail = '0;
    wait_edges(10);
    btn_rail = 5'b01000;
    wait_edges(7);  chk_rs("man.r3", 5'b01100, 2'd0);
    btn_rail = '0;
    wait_edges(10);
    mode_manual = 1'b0;
    wait_edges(3);  chk_rs("man.exit", 5'b01100, 2'd3);
    wait_edges(18); chk_rs("man.e20", 5'b01000, 2'd3);
    wait_edges(22); chk_rs("man.e42", 5'b01000, 2'd0);
    wait_edges(5);

    // 6. Reset in the middle of a ramp
    btn_up = 1'b1;
    wait_edges(8);
    btn_up = 1'b0;
    wait_edges(25); chk_rs("rstmid.e32", 5'b01111, 2'd1);
    rst = 1'b1;
    wait_edges(1);  chk_rs("rstmid.e33", 5'b01000, 2'd0);
    chk("rstmid.busy", {7'b0, busy}, 8'd0);
    rst = 1'b0;
    wait_edges(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
